// File: rtl/booth_pkg.sv
// Shared definitions for the Booth datapath shift register: command
// encodings, controller state type and a command classifier.
package booth_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_CLEAR = 3'b010;
    localparam logic [2:0] OP_ASR   = 3'b011;
    localparam logic [2:0] OP_LSR   = 3'b100;
    localparam logic [2:0] OP_SHL   = 3'b101;
    localparam logic [2:0] OP_ROR   = 3'b110;
    localparam logic [2:0] OP_RSV   = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // True for the four commands that move bits one position per clock.
    function automatic logic is_shift_op(input logic [2:0] op);
        logic res;
        case (op)
            OP_ASR, OP_LSR, OP_SHL, OP_ROR: res = 1'b1;
            default:                        res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/booth_shift_step.sv
// Combinational single-position shift of a WIDTH-bit vector; reports the
// bit that leaves the vector so the caller can expose it as Q(-1).
module booth_shift_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_vec,
    input  logic [2:0]       i_op,
    input  logic             i_serial_in,
    output logic [WIDTH-1:0] o_vec,
    output logic             o_exit
);

    // One-bit move for the selected shift kind; non-shift codes pass through.
    always_comb begin
        o_vec  = i_vec;
        o_exit = 1'b0;
        case (i_op)
            OP_ASR: begin
                o_vec  = {i_vec[WIDTH-1], i_vec[WIDTH-1:1]};
                o_exit = i_vec[0];
            end
            OP_LSR: begin
                o_vec  = {i_serial_in, i_vec[WIDTH-1:1]};
                o_exit = i_vec[0];
            end
            OP_SHL: begin
                o_vec  = {i_vec[WIDTH-2:0], 1'b0};
                o_exit = i_vec[WIDTH-1];
            end
            OP_ROR: begin
                o_vec  = {i_vec[0], i_vec[WIDTH-1:1]};
                o_exit = i_vec[0];
            end
            default: begin
                o_vec  = i_vec;
                o_exit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/booth_shift_reg.sv
// Multi-mode operand register for the Booth A/Q path: single-cycle
// load/clear and one-bit-per-clock shifts under a valid/ready handshake.
module booth_shift_reg
    import booth_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    input  logic [2:0]       i_op_code,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic [CNT_W-1:0] i_shift_amt,
    input  logic             i_serial_in,
    output logic [WIDTH-1:0] o_data_out,
    output logic             o_serial_out,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] LP_MAX_AMT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_ZERO    = CNT_W'(0);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_op, w_op_nxt;
    logic [WIDTH-1:0] r_data, w_data_nxt;
    logic             r_sout, w_sout_nxt;
    logic             r_done, w_done_nxt;

    logic             w_accept;
    logic [CNT_W-1:0] w_amt_eff;
    logic [2:0]       w_step_op;
    logic [WIDTH-1:0] w_step_vec;
    logic             w_step_exit;

    assign w_accept  = i_op_valid && (r_state == IDLE);
    assign w_amt_eff = (i_shift_amt > LP_MAX_AMT) ? LP_MAX_AMT : i_shift_amt;
    // While shifting, the latched command drives the step; otherwise the new one.
    assign w_step_op = (r_state == SHIFT) ? r_op : i_op_code;

    booth_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_vec       (r_data),
        .i_op        (w_step_op),
        .i_serial_in (i_serial_in),
        .o_vec       (w_step_vec),
        .o_exit      (w_step_exit)
    );

    // Next-state, counter and datapath update for both controller states.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_data_nxt  = r_data;
        w_sout_nxt  = r_sout;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_done_nxt = 1'b1;
                    if (i_op_code == OP_LOAD) begin
                        w_data_nxt = i_data_in;
                        w_sout_nxt = 1'b0;
                    end else if (i_op_code == OP_CLEAR) begin
                        w_data_nxt = '0;
                        w_sout_nxt = 1'b0;
                    end else if (is_shift_op(i_op_code) && (w_amt_eff != LP_ZERO)) begin
                        // First bit moves on the acceptance edge itself.
                        w_data_nxt = w_step_vec;
                        w_sout_nxt = w_step_exit;
                        if (w_amt_eff != LP_ONE) begin
                            w_done_nxt  = 1'b0;
                            w_state_nxt = SHIFT;
                            w_cnt_nxt   = w_amt_eff - LP_ONE;
                            w_op_nxt    = i_op_code;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_data_nxt = r_data;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                w_data_nxt = w_step_vec;
                w_sout_nxt = w_step_exit;
                if (r_cnt == LP_ONE) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = LP_ZERO;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - LP_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = LP_ZERO;
            end
        endcase
    end

    // State and datapath registers; reset also aborts any shift in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= LP_ZERO;
            r_op    <= OP_NOP;
            r_data  <= '0;
            r_sout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_data  <= w_data_nxt;
            r_sout  <= w_sout_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_data_out   = r_data;
    assign o_serial_out = r_sout;
    assign o_busy       = (r_state == SHIFT);
    assign o_op_ready   = (r_state == IDLE);
    assign o_done       = r_done;

endmodule

// File: tb/tb_booth_shift_reg.sv
// Self-checking bench for booth_shift_reg (WIDTH=16): directed scenarios
// plus randomized commands against a whole-shift arithmetic reference.
module tb_booth_shift_reg;
    import booth_pkg::*;

    localparam int W  = 16;
    localparam int CW = 5;

    logic          clk;
    logic          rst;
    logic          i_op_valid;
    logic          o_op_ready;
    logic [2:0]    i_op_code;
    logic [W-1:0]  i_data_in;
    logic [CW-1:0] i_shift_amt;
    logic          i_serial_in;
    logic [W-1:0]  o_data_out;
    logic          o_serial_out;
    logic          o_busy;
    logic          o_done;

    int            checks_s;
    int            errors_s;
    logic [W-1:0]  m_data;
    logic          m_sout;

    booth_shift_reg #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_op_valid   (i_op_valid),
        .o_op_ready   (o_op_ready),
        .i_op_code    (i_op_code),
        .i_data_in    (i_data_in),
        .i_shift_amt  (i_shift_amt),
        .i_serial_in  (i_serial_in),
        .o_data_out   (o_data_out),
        .o_serial_out (o_serial_out),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_s = checks_s + 1;
        if (obs !== exp) begin
            errors_s = errors_s + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole shift by n (1..16) in one arithmetic step; returns {exited bit, result}.
    function automatic logic [W:0] ref_shift(input logic [2:0] op, input logic [W-1:0] d,
                                             input int n, input logic sin);
        logic [31:0] x;
        logic [31:0] r;
        logic        so;
        x  = {16'h0000, d};
        r  = x;
        so = 1'b0;
        case (op)
            OP_ASR: begin
                r  = ({{16{d[W-1]}}, d} >> n) & 32'h0000_FFFF;
                so = x[n-1];
            end
            OP_LSR: begin
                r  = (x >> n) | (sin ? ((32'h0000_FFFF << (W - n)) & 32'h0000_FFFF) : 32'h0);
                so = x[n-1];
            end
            OP_SHL: begin
                r  = (x << n) & 32'h0000_FFFF;
                so = x[W-n];
            end
            OP_ROR: begin
                r  = ((x >> n) | (x << (W - n))) & 32'h0000_FFFF;
                so = x[n-1];
            end
            default: begin
                r  = x;
                so = 1'b0;
            end
        endcase
        return {so, r[W-1:0]};
    endfunction

    // Issues one command at the current negedge, follows it to done and checks
    // latency, busy length and the resulting register contents.
    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] d, input int amt,
                           input logic sin, input bit hold_junk);
        int         n;
        int         exp_cyc;
        int         cyc;
        int         busy_cnt;
        bit         got;
        logic [W:0] res;
        n = (amt > W) ? W : amt;
        i_op_code   = op;
        i_data_in   = d;
        i_shift_amt = CW'(amt);
        i_serial_in = sin;
        i_op_valid  = 1'b1;
        if (op == OP_LOAD) begin
            m_data = d;
            m_sout = 1'b0;
        end else if (op == OP_CLEAR) begin
            m_data = '0;
            m_sout = 1'b0;
        end else if (is_shift_op(op) && n > 0) begin
            res    = ref_shift(op, m_data, n, sin);
            m_data = res[W-1:0];
            m_sout = res[W];
        end
        exp_cyc  = (is_shift_op(op) && n >= 2) ? n : 1;
        cyc      = 0;
        busy_cnt = 0;
        got      = 1'b0;
        @(posedge clk);
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc = cyc + 1;
            if (o_done) begin
                got        = 1'b1;
                i_op_valid = 1'b0;
            end else if (hold_junk) begin
                i_op_code  = OP_LOAD;
                i_data_in  = 16'hFFFF;
                i_op_valid = 1'b1;
            end else begin
                i_op_valid = 1'b0;
            end
            if (o_busy) busy_cnt = busy_cnt + 1;
        end
        chk("done_cycle", cyc, exp_cyc);
        chk("busy_cycles", busy_cnt, exp_cyc - 1);
        chk("ready_at_done", {31'b0, o_op_ready}, 32'd1);
        chk("data_out", {16'b0, o_data_out}, {16'b0, m_data});
        chk("serial_out", {31'b0, o_serial_out}, {31'b0, m_sout});
    endtask

    initial begin
        logic [2:0] rop;
        checks_s    = 0;
        errors_s    = 0;
        m_data      = '0;
        m_sout      = 1'b0;
        rst         = 1'b1;
        i_op_valid  = 1'b0;
        i_op_code   = OP_NOP;
        i_data_in   = '0;
        i_shift_amt = '0;
        i_serial_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_data", {16'b0, o_data_out}, 32'h0);
        chk("rst_sout", {31'b0, o_serial_out}, 32'h0);
        chk("rst_busy", {31'b0, o_busy}, 32'h0);
        chk("rst_done", {31'b0, o_done}, 32'h0);
        chk("rst_ready", {31'b0, o_op_ready}, 32'h1);

        // LOAD then back-to-back CLEAR, then done must drop after one cycle.
        run_cmd(OP_LOAD, 16'hB3C5, 0, 1'b0, 1'b0);
        chk("load_val", {16'b0, o_data_out}, 32'h0000_B3C5);
        run_cmd(OP_CLEAR, 16'h0000, 0, 1'b0, 1'b0);
        chk("clear_val", {16'b0, o_data_out}, 32'h0);
        @(negedge clk);
        chk("done_one_cycle", {31'b0, o_done}, 32'h0);

        // ASR 3 with an ignored LOAD held during busy.
        run_cmd(OP_LOAD, 16'hB3C5, 0, 1'b0, 1'b0);
        run_cmd(OP_ASR, 16'h0000, 3, 1'b0, 1'b1);
        chk("asr3_val", {16'b0, o_data_out}, 32'h0000_F678);
        chk("asr3_sout", {31'b0, o_serial_out}, 32'h1);

        run_cmd(OP_LOAD, 16'h0001, 0, 1'b0, 1'b0);
        run_cmd(OP_SHL, 16'h0000, 20, 1'b0, 1'b0);
        chk("shl_clip_val", {16'b0, o_data_out}, 32'h0);
        chk("shl_clip_sout", {31'b0, o_serial_out}, 32'h1);

        run_cmd(OP_LOAD, 16'h00F0, 0, 1'b0, 1'b0);
        run_cmd(OP_LSR, 16'h0000, 4, 1'b1, 1'b0);
        chk("lsr4_val", {16'b0, o_data_out}, 32'h0000_F00F);
        chk("lsr4_sout", {31'b0, o_serial_out}, 32'h0);

        // ROR 8 aborted by reset on the third edge after acceptance.
        run_cmd(OP_LOAD, 16'h1234, 0, 1'b0, 1'b0);
        i_op_code   = OP_ROR;
        i_shift_amt = CW'(8);
        i_op_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_op_valid = 1'b0;
        @(negedge clk);
        chk("ror_mid_busy", {31'b0, o_busy}, 32'h1);
        chk("ror_mid_val", {16'b0, o_data_out}, {16'b0, ref_shift(OP_ROR, 16'h1234, 2, 1'b0)});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_data", {16'b0, o_data_out}, 32'h0);
        chk("abort_sout", {31'b0, o_serial_out}, 32'h0);
        chk("abort_busy", {31'b0, o_busy}, 32'h0);
        chk("abort_ready", {31'b0, o_op_ready}, 32'h1);
        chk("abort_done", {31'b0, o_done}, 32'h0);
        m_data = '0;
        m_sout = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'b0, o_done}, 32'h0);
        end
        run_cmd(OP_LOAD, 16'h00AA, 0, 1'b0, 1'b0);
        chk("post_abort_load", {16'b0, o_data_out}, 32'h0000_00AA);

        // Randomized commands against the reference model.
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            run_cmd(rop, 16'($urandom), $urandom_range(0, 20), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                chk("rand_done_drop", {31'b0, o_done}, 32'h0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks_s, errors_s);
        $finish;
    end

endmodule
